// File: rtl/osc_freq_meter_pkg.sv
// ============================================================================
// Module      : osc_freq_meter_pkg
// Description : Shared types and default widths for the oscillator meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package osc_freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } meter_state_t;

    localparam int GATE_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

endpackage

`default_nettype wire

// File: rtl/osc_edge_sync.sv
// ============================================================================
// Module      : osc_edge_sync
// Description : Synchronizer chain plus rising-edge detector for an async input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module osc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic Reset,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev_q tracks the synchronized level even while idle, so a level that
    // is already high when a window opens never looks like a fresh edge.
    assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/osc_freq_meter.sv
// ============================================================================
// Module      : osc_freq_meter
// Description : Counts oscillator rising edges over a programmable gate window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module osc_freq_meter
    import osc_freq_meter_pkg::*;
#(
    parameter int GATE_W      = GATE_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              osc_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_t      state_q, state_d;
    logic [GATE_W-1:0] win_rem_q, win_rem_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              osc_edge;

    osc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clock    (clock),
        .Reset    (Reset),
        .async_in (osc_in),
        .edge_out (osc_edge)
    );

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            win_rem_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_rem_q <= win_rem_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        win_rem_d = win_rem_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (gate_len != '0) begin
                        state_d   = MEASURE;
                        win_rem_d = gate_len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            MEASURE: begin
                win_rem_d = win_rem_q - GATE_W'(1);
                // Saturate rather than wrap so a too-long window stays visible.
                if (osc_edge) begin
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (win_rem_q == GATE_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == MEASURE);
        done = (state_q == DONE);
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_osc_freq_meter.sv
// ============================================================================
// Module      : tb_osc_freq_meter
// Description : Directed self-checking bench for osc_freq_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_osc_freq_meter;

    logic        clock;
    logic        Reset;
    logic        osc_in;
    logic        start16;
    logic        start8;
    logic [15:0] gate_len;
    logic        busy16, done16, ovf16;
    logic [15:0] count16;
    logic        busy8, done8, ovf8;
    logic [7:0]  count8;

    logic [1:0]  osc_mode;   // 0: low, 1: high, 2: period-4 square wave
    logic [1:0]  ph;

    int total;
    int bad;

    osc_freq_meter #(.GATE_W(16), .CNT_W(16), .SYNC_STAGES(2)) dut16 (
        .clock    (clock),
        .Reset    (Reset),
        .osc_in   (osc_in),
        .start    (start16),
        .gate_len (gate_len),
        .busy     (busy16),
        .done     (done16),
        .count    (count16),
        .overflow (ovf16)
    );

    osc_freq_meter #(.GATE_W(16), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clock    (clock),
        .Reset    (Reset),
        .osc_in   (osc_in),
        .start    (start8),
        .gate_len (gate_len),
        .busy     (busy8),
        .done     (done8),
        .count    (count8),
        .overflow (ovf8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Oscillator changes on the falling edge: 2 cycles high, 2 cycles low.
    always @(negedge clock) begin
        if (osc_mode == 2'd2) begin
            ph     = ph + 2'd1;
            osc_in = ph[1];
        end else begin
            osc_in = osc_mode[0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Issue start, optionally re-pulse start at window cycle restart_at, then
    // check done latency, busy duration, result, and that done is one cycle.
    task automatic measure(input string tag, input bit sel, input int g,
                           input int exp_cnt, input bit exp_ovf, input int restart_at);
        int n;
        int busy_n;
        bit seen;
        gate_len = g[15:0];
        if (sel) start8 = 1'b1; else start16 = 1'b1;
        @(negedge clock);
        start8  = 1'b0;
        start16 = 1'b0;
        n      = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && n <= g + 20) begin
            if (restart_at != 0 && n == restart_at) begin
                if (sel) start8 = 1'b1; else start16 = 1'b1;
            end else begin
                start8  = 1'b0;
                start16 = 1'b0;
            end
            if ((sel ? done8 : done16) === 1'b1) begin
                seen = 1'b1;
            end else begin
                if ((sel ? busy8 : busy16) === 1'b1) busy_n++;
                @(negedge clock);
                n++;
            end
        end
        start8  = 1'b0;
        start16 = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_done_latency"}, n, g + 1);
        chk({tag, "_busy_cycles"}, busy_n, g);
        chk({tag, "_count"}, sel ? {24'd0, count8} : {16'd0, count16}, exp_cnt);
        chk({tag, "_overflow"}, 32'(sel ? ovf8 : ovf16), 32'(exp_ovf));
        chk({tag, "_busy_at_done"}, 32'(sel ? busy8 : busy16), 32'd0);
        @(negedge clock);
        chk({tag, "_done_one_cycle"}, 32'(sel ? done8 : done16), 32'd0);
        chk({tag, "_count_held"}, sel ? {24'd0, count8} : {16'd0, count16}, exp_cnt);
    endtask

    initial begin
        int dones;
        total    = 0;
        bad      = 0;
        Reset    = 1'b0;
        osc_in   = 1'b0;
        osc_mode = 2'd2;
        ph       = 2'd0;
        start16  = 1'b0;
        start8   = 1'b0;
        gate_len = 16'd0;

        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_count", {16'd0, count16}, 32'd0);
        chk("rst_ovf", 32'(ovf16), 32'd0);
        chk("rst_count8", {24'd0, count8}, 32'd0);
        Reset = 1'b1;
        repeat (10) @(negedge clock);

        // Steady period-4 oscillator, 100-cycle window
        measure("t1", 1'b0, 100, 25, 1'b0, 0);

        // Static levels: no edges counted, including a level already high
        osc_mode = 2'd0;
        repeat (10) @(negedge clock);
        measure("t2_low", 1'b0, 50, 0, 1'b0, 0);
        osc_mode = 2'd1;
        repeat (10) @(negedge clock);
        measure("t2_high", 1'b0, 50, 0, 1'b0, 0);

        // Saturation on the 8-bit counter, then a clean run clears overflow
        osc_mode = 2'd2;
        repeat (10) @(negedge clock);
        measure("t3_sat", 1'b1, 2000, 255, 1'b1, 0);
        measure("t3_clr", 1'b1, 40, 10, 1'b0, 0);

        // Zero-length window
        measure("t4_zero", 1'b0, 0, 0, 1'b0, 0);

        // Start re-pulsed 10 cycles into the window is ignored
        measure("t5_restart", 1'b0, 100, 25, 1'b0, 10);

        // Asynchronous reset mid-window
        gate_len = 16'd100;
        start16  = 1'b1;
        @(negedge clock);
        start16 = 1'b0;
        repeat (29) @(negedge clock);
        chk("t6_busy_before", 32'(busy16), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy16), 32'd0);
        chk("t6_rst_done", 32'(done16), 32'd0);
        chk("t6_rst_count", {16'd0, count16}, 32'd0);
        chk("t6_rst_ovf", 32'(ovf16), 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clock);
            if (done16 === 1'b1) dones++;
        end
        Reset = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (done16 === 1'b1) dones++;
        end
        chk("t6_no_done", dones, 0);
        measure("t6_after", 1'b0, 20, 5, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
